ram_mport: RTL

RAM_MPORT -- requirements
Module: ram_mport

---
 rtl/ram_mport_pkg.sv | 13 +
 rtl/ram_clear_fsm.sv | 58 +++++
 rtl/ram_mport.sv | 95 +++++++++
 3 files changed

// File: rtl/ram_mport_pkg.sv
// Shared types and limits for the multi-port RAM and its clear sequencer.
package ram_mport_pkg;

    // Upper bound on the number of read ports the RAM supports
    localparam int MAX_NUM_RD = 8;

    // Clear sequencer states
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear sequencer: walks every address once, zeroing one word per cycle.
// Comes out of reset in CLEAR so the memory is always zeroed before use.
module ram_clear_fsm
    import ram_mport_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    clr_state_e            state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_nxt;

    // State and pointer registers; reset restarts the sweep from address 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // Next state: clr is only honoured from IDLE, so a clear cannot be re-armed mid-sweep
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt   = CLEAR;
                    clr_ptr_nxt = '0;
                end
            end
            CLEAR: begin
                clr_ptr_nxt = clr_ptr + 1'b1;
                if (clr_ptr == LAST_ADDR) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: every CLEAR cycle issues a zero-write at the current pointer
    always_comb begin
        busy     = (state == CLEAR);
        clr_we   = (state == CLEAR);
        clr_addr = clr_ptr;
    end

endmodule

// File: rtl/ram_mport.sv
// Single-write, multi-read RAM with per-lane byte enables and a self-clear
// sequence. Each read port is async or sync (1-cycle) per ASYNC_MASK.
// Optional feature: define RAM_BYPASS_EN for write-first sync reads;
// otherwise sync reads that collide with a write return the old word.
module ram_mport
    import ram_mport_pkg::*;
#(
    parameter int                ADDR_WIDTH = 3,
    parameter int                DATA_WIDTH = 8,
    parameter int                LANE_WIDTH = 8,
    parameter int                NUM_RD     = 2,
    parameter logic [NUM_RD-1:0] ASYNC_MASK = NUM_RD'(1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         we,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] w_be,
    input  logic [ADDR_WIDTH-1:0]        w_addr,
    input  logic [DATA_WIDTH-1:0]        w_data,
    input  logic [NUM_RD-1:0]            r_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] r_data,
    output logic                         busy
);

    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_acc;

    ram_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // User writes are dropped outright while the clear sweep owns the array
    assign wr_acc = we & ~busy;

    // Memory array: clear zero-write takes priority; no reset on the storage itself
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (w_be[k]) mem[w_addr][k*LANE_WIDTH +: LANE_WIDTH] <= w_data[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = r_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        if (ASYNC_MASK[i]) begin : g_async
            // r_en has no meaning on an async port
            logic unused_en;
            assign unused_en = r_en[i];
            assign r_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
        end else begin : g_sync
            logic [DATA_WIDTH-1:0] rd_word;
            logic [DATA_WIDTH-1:0] q;
`ifdef RAM_BYPASS_EN
            // Write-first: forward enabled lanes of a colliding accepted write
            always_comb begin
                rd_word = mem[ra];
                if (wr_acc && (ra == w_addr)) begin
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (w_be[k]) rd_word[k*LANE_WIDTH +: LANE_WIDTH] = w_data[k*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
`else
            // Read-first: the registered word is the pre-write contents
            assign rd_word = mem[ra];
`endif
            // Sync read register: loads on r_en, otherwise holds
            always_ff @(posedge clk or posedge reset) begin
                if (reset)        q <= '0;
                else if (r_en[i]) q <= rd_word;
            end
            assign r_data[i*DATA_WIDTH +: DATA_WIDTH] = q;
        end
    end

endmodule
